arm_execute_unit: RTL and testbench

- Execute-stage arithmetic block of the single-cycle ARM core.
- Computes PC+4 and PC+8 and extends the instruction immediate.
- Selects the ALU second operand, performs the 16 ARM data-processing operations, and holds the NZCV status flags in a register.
- Sits between the register file and the result/PC muxes in the datapath.

---
 rtl/arm_execute_unit.sv | 112 +++++++++++
 tb/tb_arm_execute_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/arm_execute_unit.sv
// Execute-stage arithmetic for the single-cycle ARM core: PC increments,
// immediate extension, SrcB select, 16-op ALU and the NZCV status register.
module arm_execute_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC,
    input  logic [23:0] Instr,
    input  logic [1:0]  ImmSrc,
    input  logic        ALUSrc,
    input  logic [31:0] SrcA,
    input  logic [31:0] RegB,
    input  logic [3:0]  ALUControl,
    input  logic [1:0]  FlagWrite,
    output logic [31:0] PCPlus4,
    output logic [31:0] PCPlus8,
    output logic [31:0] ExtImm,
    output logic [31:0] ALUResult,
    output logic [3:0]  ALUFlags,
    output logic [3:0]  Flags,
    output logic        NoWrite
);

    logic [3:0]  flags_q, flags_d;
    logic [31:0] src_b;
    logic [31:0] rot_imm;
    logic [63:0] rot_dbl;
    logic [31:0] add_x, add_y;
    logic        add_c;
    logic        is_arith;
    logic [32:0] sum;
    logic        cin;

    assign PCPlus4 = PC + 32'd4;
    assign PCPlus8 = PC + 32'd8;

    // Rotate-right of the 8-bit immediate done as a shift of a doubled word
    assign rot_dbl = {24'h0, Instr[7:0], 24'h0, Instr[7:0]} >> {Instr[11:8], 1'b0};
    assign rot_imm = rot_dbl[31:0];

    // Immediate format decode
    always_comb begin
        case (ImmSrc)
            2'b00:   ExtImm = rot_imm;
            2'b01:   ExtImm = {20'h0, Instr[11:0]};
            2'b10:   ExtImm = {{6{Instr[23]}}, Instr, 2'b00};
            default: ExtImm = 32'h0;
        endcase
    end

    assign src_b = ALUSrc ? ExtImm : RegB;
    assign cin   = flags_q[1];

    // Adder operand steering: every arithmetic op is X + Y + c
    always_comb begin
        add_x    = SrcA;
        add_y    = src_b;
        add_c    = 1'b0;
        is_arith = 1'b1;
        case (ALUControl)
            4'b0010, 4'b1010: begin add_y = ~src_b; add_c = 1'b1; end
            4'b0011:          begin add_x = src_b; add_y = ~SrcA; add_c = 1'b1; end
            4'b0100, 4'b1011: add_c = 1'b0;
            4'b0101:          add_c = cin;
            4'b0110:          begin add_y = ~src_b; add_c = cin; end
            4'b0111:          begin add_x = src_b; add_y = ~SrcA; add_c = cin; end
            default:          is_arith = 1'b0;
        endcase
    end

    assign sum = {1'b0, add_x} + {1'b0, add_y} + {32'h0, add_c};

    // Result select; logical ops pass the held C,V through unchanged
    always_comb begin
        ALUResult = sum[31:0];
        case (ALUControl)
            4'b0000, 4'b1000: ALUResult = SrcA & src_b;
            4'b0001, 4'b1001: ALUResult = SrcA ^ src_b;
            4'b1100:          ALUResult = SrcA | src_b;
            4'b1101:          ALUResult = src_b;
            4'b1110:          ALUResult = SrcA & ~src_b;
            4'b1111:          ALUResult = ~src_b;
            default:          ALUResult = sum[31:0];
        endcase
        ALUFlags[3] = ALUResult[31];
        ALUFlags[2] = (ALUResult == 32'h0);
        if (is_arith) begin
            ALUFlags[1] = sum[32];
            ALUFlags[0] = (add_x[31] == add_y[31]) && (sum[31] != add_x[31]);
        end else begin
            ALUFlags[1] = flags_q[1];
            ALUFlags[0] = flags_q[0];
        end
    end

    assign NoWrite = (ALUControl[3:2] == 2'b10);

    // Per-pair flag write enables: [1] gates N,Z and [0] gates C,V
    always_comb begin
        flags_d = flags_q;
        if (FlagWrite[1]) flags_d[3:2] = ALUFlags[3:2];
        if (FlagWrite[0]) flags_d[1:0] = ALUFlags[1:0];
    end

    // Status register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) flags_q <= 4'b0000;
        else        flags_q <= flags_d;
    end

    assign Flags = flags_q;

endmodule

// File: tb/tb_arm_execute_unit.sv
// Scoreboard bench for arm_execute_unit: expected outputs are queued when
// inputs are driven and compared at the following falling edge.
module tb_arm_execute_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc;
    logic [23:0] instr;
    logic [1:0]  imm_src;
    logic        alu_src;
    logic [31:0] src_a, reg_b;
    logic [3:0]  alu_ctl;
    logic [1:0]  flag_wr;
    logic [31:0] pc4, pc8, ext_imm, alu_res;
    logic [3:0]  alu_flags, flags;
    logic        no_write;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] pc4;
        logic [31:0] pc8;
        logic [31:0] ext;
        logic [3:0]  aflags;
        logic [3:0]  flags;
        logic        nw;
    } exp_t;

    exp_t       sb_q[$];
    logic [3:0] m_flags;
    int         n_checks;
    int         n_errors;

    arm_execute_unit dut (
        .clk       (clk),
        .reset     (rst_n),
        .PC        (pc),
        .Instr     (instr),
        .ImmSrc    (imm_src),
        .ALUSrc    (alu_src),
        .SrcA      (src_a),
        .RegB      (reg_b),
        .ALUControl(alu_ctl),
        .FlagWrite (flag_wr),
        .PCPlus4   (pc4),
        .PCPlus8   (pc8),
        .ExtImm    (ext_imm),
        .ALUResult (alu_res),
        .ALUFlags  (alu_flags),
        .Flags     (flags),
        .NoWrite   (no_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ext_model(input logic [1:0] isrc, input logic [23:0] ins);
        logic [31:0] v;
        v = 32'h0;
        case (isrc)
            2'b00: begin
                v = {24'h0, ins[7:0]};
                for (int i = 0; i < 2 * int'(ins[11:8]); i++) v = {v[0], v[31:1]};
            end
            2'b01: v = {20'h0, ins[11:0]};
            2'b10: v = ins[23] ? {6'h3F, ins, 2'b00} : {6'h00, ins, 2'b00};
            default: v = 32'h0;
        endcase
        return v;
    endfunction

    function automatic exp_t alu_model(input logic [3:0] op, input logic [31:0] a,
                                       input logic [31:0] b, input logic [3:0] fl);
        exp_t        e;
        logic [31:0] x, y, r;
        logic        c, arith, cf, vf;
        logic [32:0] s;
        logic [33:0] ss;
        x = a; y = b; c = 1'b0; arith = 1'b1; r = 32'h0;
        case (op)
            4'h2, 4'hA: begin y = ~b; c = 1'b1; end
            4'h3:       begin x = b; y = ~a; c = 1'b1; end
            4'h4, 4'hB: c = 1'b0;
            4'h5:       c = fl[1];
            4'h6:       begin y = ~b; c = fl[1]; end
            4'h7:       begin x = b; y = ~a; c = fl[1]; end
            default:    arith = 1'b0;
        endcase
        s  = {1'b0, x} + {1'b0, y} + {32'h0, c};
        ss = {{2{x[31]}}, x} + {{2{y[31]}}, y} + {33'h0, c};
        case (op)
            4'h0, 4'h8: r = a & b;
            4'h1, 4'h9: r = a ^ b;
            4'hC:       r = a | b;
            4'hD:       r = b;
            4'hE:       r = a & ~b;
            4'hF:       r = ~b;
            default:    r = s[31:0];
        endcase
        cf = arith ? s[32] : fl[1];
        vf = arith ? (ss[32] != ss[31]) : fl[0];
        e = '0;
        e.res    = r;
        e.aflags = {r[31], r == 32'h0, cf, vf};
        e.nw     = (op >= 4'h8) && (op <= 4'hB);
        return e;
    endfunction

    // Drive one vector just after a rising edge, check at the falling edge,
    // then advance the flag model across the next rising edge.
    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] rb,
                         input logic asrc, input logic [1:0] isrc, input logic [23:0] ins,
                         input logic [1:0] fw, input logic [31:0] p);
        exp_t        e;
        exp_t        g;
        logic [31:0] ext;
        alu_ctl = op; src_a = a; reg_b = rb; alu_src = asrc;
        imm_src = isrc; instr = ins; flag_wr = fw; pc = p;
        ext = ext_model(isrc, ins);
        e = alu_model(op, a, asrc ? ext : rb, m_flags);
        e.ext   = ext;
        e.pc4   = p + 32'd4;
        e.pc8   = p + 32'd8;
        e.flags = m_flags;
        sb_q.push_back(e);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        g = sb_q.pop_front();
        check("pc4",      pc4, g.pc4);
        check("pc8",      pc8, g.pc8);
        check("ext_imm",  ext_imm, g.ext);
        check("alu_res",  alu_res, g.res);
        check("alu_flags", {28'h0, alu_flags}, {28'h0, g.aflags});
        check("flags",    {28'h0, flags}, {28'h0, g.flags});
        check("no_write", {31'h0, no_write}, {31'h0, g.nw});
        @(posedge clk);
        if (!rst_n) m_flags = 4'b0000;
        else begin
            if (fw[1]) m_flags[3:2] = g.aflags[3:2];
            if (fw[0]) m_flags[1:0] = g.aflags[1:0];
        end
        #1;
    endtask

    initial begin
        n_checks = 0; n_errors = 0; m_flags = 4'b0000;
        rst_n = 1'b0; pc = 32'h0; instr = 24'h0; imm_src = 2'b00; alu_src = 1'b0;
        src_a = 32'h0; reg_b = 32'h0; alu_ctl = 4'h0; flag_wr = 2'b00;
        @(posedge clk); #1;
        check("reset_flags", {28'h0, flags}, 32'h0);
        // reset beats FlagWrite even when the op would set flags
        drive(4'h4, 32'hFFFFFFFF, 32'h1, 1'b0, 2'b00, 24'h0, 2'b11, 32'h0);
        check("reset_over_fw", {28'h0, flags}, 32'h0);
        rst_n = 1'b1;

        // PC increments and wrap
        drive(4'h4, 32'h0, 32'h0, 1'b0, 2'b00, 24'h0, 2'b00, 32'h00001000);
        check("pc4_1000", pc4, 32'h00001004);
        check("pc8_1000", pc8, 32'h00001008);
        drive(4'h4, 32'h0, 32'h0, 1'b0, 2'b00, 24'h0, 2'b00, 32'hFFFFFFFC);
        check("pc4_wrap", pc4, 32'h00000000);
        check("pc8_wrap", pc8, 32'h00000004);

        // Immediate formats, MOV of the immediate
        drive(4'hD, 32'h0, 32'h0, 1'b1, 2'b00, 24'h0004FF, 2'b00, 32'h0);
        check("ext_rot", ext_imm, 32'hFF000000);
        drive(4'hD, 32'h0, 32'h0, 1'b1, 2'b01, 24'h000ABC, 2'b00, 32'h0);
        check("ext_12", ext_imm, 32'h00000ABC);
        drive(4'hD, 32'h0, 32'h0, 1'b1, 2'b10, 24'h800001, 2'b00, 32'h0);
        check("ext_br", ext_imm, 32'hFE000004);
        drive(4'hD, 32'h0, 32'h0, 1'b1, 2'b11, 24'hFFFFFF, 2'b00, 32'h0);
        check("ext_zero", ext_imm, 32'h0);

        // Arithmetic flags
        drive(4'h4, 32'h7FFFFFFF, 32'h1, 1'b0, 2'b00, 24'h0, 2'b11, 32'h0);
        check("flags_add_ovf", {28'h0, flags}, 32'h9);
        drive(4'h2, 32'h5, 32'h5, 1'b0, 2'b00, 24'h0, 2'b11, 32'h0);
        check("flags_sub_zero", {28'h0, flags}, 32'h6);
        drive(4'hA, 32'h3, 32'h5, 1'b0, 2'b00, 24'h0, 2'b11, 32'h0);
        check("flags_cmp", {28'h0, flags}, 32'h8);

        // Carry chain
        drive(4'h4, 32'hFFFFFFFF, 32'h1, 1'b0, 2'b00, 24'h0, 2'b11, 32'h0);
        check("flags_add_carry", {28'h0, flags}, 32'h6);
        drive(4'h5, 32'h1, 32'h1, 1'b0, 2'b00, 24'h0, 2'b00, 32'h0);
        drive(4'h6, 32'h5, 32'h1, 1'b0, 2'b00, 24'h0, 2'b00, 32'h0);
        drive(4'h7, 32'h1, 32'h9, 1'b0, 2'b00, 24'h0, 2'b00, 32'h0);

        // Set C,V then a logical op keeps them
        drive(4'h2, 32'h80000000, 32'h1, 1'b0, 2'b00, 24'h0, 2'b11, 32'h0);
        check("flags_cv_set", {28'h0, flags}, 32'h3);
        drive(4'h0, 32'hF0F0F0F0, 32'h0F0F0F0F, 1'b0, 2'b00, 24'h0, 2'b11, 32'h0);
        check("flags_and_keep", {28'h0, flags}, 32'h7);
        drive(4'hE, 32'hFFFF0000, 32'hF00FF00F, 1'b0, 2'b00, 24'h0, 2'b11, 32'h0);
        drive(4'hF, 32'h0, 32'h0, 1'b0, 2'b00, 24'h0, 2'b00, 32'h0);
        drive(4'hC, 32'h12340000, 32'h00005678, 1'b0, 2'b00, 24'h0, 2'b00, 32'h0);
        drive(4'h9, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 2'b00, 24'h0, 2'b10, 32'h0);
        drive(4'h8, 32'h0000FF00, 32'h00FF0000, 1'b0, 2'b00, 24'h0, 2'b00, 32'h0);
        drive(4'h1, 32'h12345678, 32'hFFFFFFFF, 1'b0, 2'b00, 24'h0, 2'b00, 32'h0);
        drive(4'h3, 32'h10, 32'h4, 1'b0, 2'b00, 24'h0, 2'b11, 32'h0);
        drive(4'hB, 32'h80000000, 32'h80000000, 1'b0, 2'b00, 24'h0, 2'b11, 32'h0);

        // FlagWrite=10 touches only N,Z
        drive(4'h4, 32'hFFFFFFFF, 32'h1, 1'b0, 2'b00, 24'h0, 2'b01, 32'h0);
        drive(4'h4, 32'h7FFFFFFF, 32'h1, 1'b0, 2'b00, 24'h0, 2'b10, 32'h0);
        check("flags_nz_only", {28'h0, flags}, 32'hA);

        // Random mix
        for (int i = 0; i < 60; i++) begin
            drive(4'($urandom_range(0, 15)), $urandom, $urandom, 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 24'($urandom), 2'($urandom_range(0, 3)), $urandom);
        end

        // Reset mid-run with flag writes enabled
        rst_n = 1'b0;
        drive(4'h4, 32'h7FFFFFFF, 32'h1, 1'b0, 2'b00, 24'h0, 2'b11, 32'h0);
        check("reset_mid", {28'h0, flags}, 32'h0);
        rst_n = 1'b1;
        drive(4'h2, 32'h0, 32'h1, 1'b0, 2'b00, 24'h0, 2'b11, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
